// File: rtl/potential_decay_engine.sv
// Pipelined float32 membrane-potential leak unit with a per-neuron rate table.
// Optional saturating output statistics are enabled with `define DECAY_STATS_EN.
`timescale 1ns/1ps
module potential_decay_engine #(
    parameter int NEURON_COUNT = 16,
    parameter int ID_WIDTH     = $clog2(NEURON_COUNT)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                cfg_we,
    input  logic [ID_WIDTH-1:0] cfg_addr,
    input  logic [2:0]          cfg_rate,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ID_WIDTH-1:0] in_neuron_id,
    input  logic [31:0]         in_potential,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_WIDTH-1:0] out_neuron_id,
    output logic [31:0]         out_potential,
    output logic                out_flushed
`ifdef DECAY_STATS_EN
    ,
    output logic [31:0]         stat_processed,
    output logic [31:0]         stat_flushed
`endif
);

    // Handshake: an item moves on a rising edge when valid && ready are both high.
    // One global advance freezes every stage while the output is held.
    logic advance;
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    logic [2:0] rate_q [NEURON_COUNT];

    logic                s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
    logic [ID_WIDTH-1:0] s1_id_q, s2_id_q, s3_id_q, out_id_q;
    logic [31:0]         s1_pot_q, s2_res_q, s3_res_q, out_pot_q;
    logic [2:0]          s1_rate_q;
    logic                s2_flush_q, s3_flush_q, out_flush_q;
    logic                s2_sub_q, s3_sub_q, s2_k3_q;
    logic [24:0]         s3_diff_q;

    logic [31:0] s2_res_d, out_pot_d;
    logic        s2_flush_d, s2_sub_d, s2_k3_d, out_flush_d;
    logic [24:0] s3_diff_d;
    logic [1:0]  diff_unused;
    logic [26:0] sig;
    logic [7:0]  shift_amt;
    logic        s1_sign, s3_sign;
    logic [7:0]  s1_exp, s3_exp;

    assign s1_sign = s1_pot_q[31];
    assign s1_exp  = s1_pot_q[30:23];
    assign s3_sign = s3_res_q[31];
    assign s3_exp  = s3_res_q[30:23];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NEURON_COUNT; i++) rate_q[i] <= 3'd0;
        end else if (cfg_we) begin
            rate_q[cfg_addr] <= cfg_rate;
        end
    end

    // Decode: specials, code 7, code 0 and the pure exponent shifts resolve here.
    always_comb begin
        shift_amt = 8'd0;
        case (s1_rate_q)
            3'd1:    shift_amt = 8'd1;
            3'd2:    shift_amt = 8'd2;
            3'd3:    shift_amt = 8'd3;
            3'd6:    shift_amt = 8'd4;
            default: shift_amt = 8'd0;
        endcase
        s2_res_d   = s1_pot_q;
        s2_flush_d = 1'b0;
        s2_sub_d   = 1'b0;
        s2_k3_d    = 1'b0;
        if (s1_rate_q == 3'd7) begin
            s2_res_d   = {s1_sign, 31'b0};
            s2_flush_d = 1'b1;
        end else if (s1_exp == 8'd0) begin
            s2_res_d = {s1_sign, 31'b0};
        end else if (s1_exp != 8'hFF) begin
            case (s1_rate_q)
                3'd4, 3'd5: begin
                    s2_sub_d = 1'b1;
                    s2_k3_d  = (s1_rate_q == 3'd5);
                end
                3'd1, 3'd2, 3'd3, 3'd6: begin
                    if (s1_exp > shift_amt) begin
                        s2_res_d = {s1_sign, s1_exp - shift_amt, s1_pot_q[22:0]};
                    end else begin
                        s2_res_d   = {s1_sign, 31'b0};
                        s2_flush_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // D = S - S>>k on the significand with 3 guard bits; guard bits below D[2] never reach the result.
    always_comb begin
        sig = {1'b1, s2_res_q[22:0], 3'b000};
        {s3_diff_d, diff_unused} = sig - (s2_k3_q ? (sig >> 3) : (sig >> 2));
    end

    always_comb begin
        out_pot_d   = s3_res_q;
        out_flush_d = s3_flush_q;
        if (s3_sub_q) begin
            if (s3_diff_q[24]) begin
                out_pot_d = {s3_sign, s3_exp, s3_diff_q[23:1]};
            end else if (s3_exp == 8'd1) begin
                out_pot_d   = {s3_sign, 31'b0};
                out_flush_d = 1'b1;
            end else begin
                out_pot_d = {s3_sign, s3_exp - 8'd1, s3_diff_q[22:0]};
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_valid_q  <= 1'b0;  s1_id_q  <= '0; s1_pot_q <= '0; s1_rate_q <= '0;
            s2_valid_q  <= 1'b0;  s2_id_q  <= '0; s2_res_q <= '0; s2_flush_q <= 1'b0;
            s2_sub_q    <= 1'b0;  s2_k3_q  <= 1'b0;
            s3_valid_q  <= 1'b0;  s3_id_q  <= '0; s3_res_q <= '0; s3_flush_q <= 1'b0;
            s3_sub_q    <= 1'b0;  s3_diff_q <= '0;
            out_valid_q <= 1'b0;  out_id_q <= '0; out_pot_q <= '0; out_flush_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s1_id_q     <= in_neuron_id;
            s1_pot_q    <= in_potential;
            s1_rate_q   <= rate_q[in_neuron_id];
            s2_valid_q  <= s1_valid_q;
            s2_id_q     <= s1_id_q;
            s2_res_q    <= s2_res_d;
            s2_flush_q  <= s2_flush_d;
            s2_sub_q    <= s2_sub_d;
            s2_k3_q     <= s2_k3_d;
            s3_valid_q  <= s2_valid_q;
            s3_id_q     <= s2_id_q;
            s3_res_q    <= s2_res_q;
            s3_flush_q  <= s2_flush_q;
            s3_sub_q    <= s2_sub_q;
            s3_diff_q   <= s3_diff_d;
            out_valid_q <= s3_valid_q;
            out_id_q    <= s3_id_q;
            out_pot_q   <= out_pot_d;
            out_flush_q <= out_flush_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_neuron_id = out_id_q;
    assign out_potential = out_pot_q;
    assign out_flushed   = out_flush_q;

`ifdef DECAY_STATS_EN
    logic [31:0] stat_processed_q, stat_flushed_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_processed_q <= '0;
            stat_flushed_q   <= '0;
        end else if (out_valid_q && out_ready) begin
            if (stat_processed_q != 32'hFFFF_FFFF) stat_processed_q <= stat_processed_q + 32'd1;
            if (out_flush_q && stat_flushed_q != 32'hFFFF_FFFF) stat_flushed_q <= stat_flushed_q + 32'd1;
        end
    end

    assign stat_processed = stat_processed_q;
    assign stat_flushed   = stat_flushed_q;
`endif

endmodule

// File: tb/tb_potential_decay_engine.sv
// Self-checking bench for potential_decay_engine: directed cases, stall stream,
// same-cycle config, random traffic with random back-pressure, and mid-flight reset.
`timescale 1ns/1ps
module tb_potential_decay_engine;
    localparam int NC = 16;
    localparam int IW = 4;
    localparam int EW = IW + 1 + 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [2:0]    cfg_rate;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_neuron_id;
    logic [31:0]   in_potential;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_neuron_id;
    logic [31:0]   out_potential;
    logic          out_flushed;
`ifdef DECAY_STATS_EN
    logic [31:0]   stat_processed, stat_flushed;
`endif

    int total = 0;
    int bad = 0;
    int hs_count = 0;
    int hs_flush = 0;
    bit rand_ready = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [2:0] model_rate [NC];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    potential_decay_engine #(.NEURON_COUNT(NC)) dut (
        .CLK(clk), .RESET(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_rate(cfg_rate),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_neuron_id(in_neuron_id), .in_potential(in_potential),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_neuron_id(out_neuron_id), .out_potential(out_potential),
        .out_flushed(out_flushed)
`ifdef DECAY_STATS_EN
        , .stat_processed(stat_processed), .stat_flushed(stat_flushed)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {flushed, result}.
    function automatic logic [32:0] model(input logic [2:0] rate, input logic [31:0] x);
        logic   s;
        int     e, k, ne;
        longint sv, dv;
        s = x[31];
        e = int'(x[30:23]);
        if (rate == 3'd7) return {1'b1, s, 31'b0};
        if (e == 0) return {1'b0, s, 31'b0};
        if (e == 255 || rate == 3'd0) return {1'b0, x};
        if (rate == 3'd4 || rate == 3'd5) begin
            k  = (rate == 3'd4) ? 2 : 3;
            sv = (longint'(x[22:0]) + (longint'(1) << 23)) * 8;
            dv = sv - (sv >> k);
            ne = e;
            if (dv < (longint'(1) << 26)) begin
                dv = dv * 2;
                ne = e - 1;
            end
            if (ne == 0) return {1'b1, s, 31'b0};
            return {1'b0, s, 8'(ne), 23'(dv >> 3)};
        end
        k = (rate == 3'd6) ? 4 : int'(rate);
        if (e > k) return {1'b0, s, 8'(e - k), x[22:0]};
        return {1'b1, s, 31'b0};
    endfunction

    function automatic logic [31:0] rand_pot();
        int c;
        logic [7:0] e;
        c = $urandom_range(0, 9);
        case (c)
            0: e = 8'd0;
            1: e = 8'd1;
            2: e = 8'd2;
            3: e = 8'd3;
            4: e = 8'd4;
            5: e = 8'd255;
            6: e = 8'd254;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- driver tasks (called just after a rising edge) ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [IW-1:0] a, input logic [2:0] r);
        cfg_we = 1'b1; cfg_addr = a; cfg_rate = r;
        @(posedge clk);
        model_rate[a] = r;
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] id, input logic [31:0] pot,
                        input bit do_cfg, input logic [IW-1:0] ca, input logic [2:0] cr);
        int w;
        logic [32:0] r;
        in_valid = 1'b1; in_neuron_id = id; in_potential = pot; w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
            in_valid = 1'b0;
            return;
        end
        if (do_cfg) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_rate = cr;
        end
        r = model(model_rate[id], pot);
        exp_q.push_back({id, r});
        if (do_cfg) model_rate[ca] = cr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic expect_next(input string name, input logic [31:0] pot, input logic fl);
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no_output required=output", name);
        end else begin
            check(name, {out_flushed, out_potential}, {fl, pot});
        end
        sync();
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL %s actual=%0d_pending required=0", name, exp_q.size());
        end
        sync();
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] held;
    bit prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall)
                check("stall_hold", {out_valid, out_neuron_id, out_flushed, out_potential}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output actual=%h required=none",
                             {out_neuron_id, out_flushed, out_potential});
                end else begin
                    e = exp_q.pop_front();
                    check("output", {out_neuron_id, out_flushed, out_potential}, e);
                end
                hs_count++;
                if (out_flushed) hs_flush++;
            end
            prev_stall = out_valid && !out_ready;
            held = {out_neuron_id, out_flushed, out_potential};
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [IW-1:0] id, ca;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_rate = '0;
        in_valid = 1'b0; in_neuron_id = '0; in_potential = '0; out_ready = 1'b1;
        for (int i = 0; i < NC; i++) model_rate[i] = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_potential", out_potential, 0);
        check("reset_out_id", out_neuron_id, 0);
        check("reset_out_flushed", out_flushed, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        sync();

        // 3-cycle latency and rate 4 on 1.0
        cfg(2, 3'd4);
        send(2, 32'h3F80_0000, 0, 0, 0);
        @(negedge clk); check("latency_c1", out_valid, 0);
        @(negedge clk); check("latency_c2", out_valid, 0);
        @(negedge clk); check("latency_c3", out_valid, 0);
        @(negedge clk); check("latency_c4", out_valid, 1);
        check("r4_1p0", {out_neuron_id, out_flushed, out_potential}, {4'd2, 1'b0, 32'h3F40_0000});
        sync();
        send(2, 32'h3FC0_0000, 0, 0, 0);
        expect_next("r4_1p5", 32'h3F90_0000, 1'b0);
        cfg(3, 3'd5);
        send(3, 32'h3F80_0000, 0, 0, 0);
        expect_next("r5_1p0", 32'h3F60_0000, 1'b0);
        cfg(4, 3'd6);
        send(4, 32'h4180_0000, 0, 0, 0);
        expect_next("r6_16", 32'h3F80_0000, 1'b0);
        cfg(6, 3'd3);
        send(6, 32'h0180_0000, 0, 0, 0);
        expect_next("r3_underflow", 32'h0000_0000, 1'b1);
        send(6, 32'h7F80_0000, 0, 0, 0);
        expect_next("r3_inf", 32'h7F80_0000, 1'b0);
        cfg(7, 3'd7);
        send(7, 32'hFF80_0000, 0, 0, 0);
        expect_next("r7_inf", 32'h8000_0000, 1'b1);
        send(8, 32'h8000_0001, 0, 0, 0);
        expect_next("denormal", 32'h8000_0000, 1'b0);
        cfg(9, 3'd4);
        send(9, 32'h0080_0000, 0, 0, 0);
        expect_next("r4_e1_flush", 32'h0000_0000, 1'b1);

        // back-to-back stream with a 4-cycle stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(4'(i), rand_pot(), 0, 0, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready_drop", in_ready, 0);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("stream_drain");

        // config write to the accepted neuron in the same cycle
        send(5, 32'h4040_0000, 1, 5, 3'd1);
        expect_next("cfg_same_cycle_old", 32'h4040_0000, 1'b0);
        send(5, 32'h4040_0000, 0, 0, 0);
        expect_next("cfg_next_new", 32'h3FC0_0000, 1'b0);

        // random traffic with random back-pressure and config writes
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            id = 4'($urandom_range(0, NC - 1));
            ca = ($urandom_range(0, 3) == 0) ? id : 4'($urandom_range(0, NC - 1));
            send(id, rand_pot(), ($urandom_range(0, 3) == 0), ca, 3'($urandom_range(0, 7)));
        end
        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        drain("random_drain");
`ifdef DECAY_STATS_EN
        check("stat_processed", stat_processed, hs_count);
        check("stat_flushed", stat_flushed, hs_flush);
`endif

        // reset with items in flight
        send(1, rand_pot(), 0, 0, 0);
        send(2, rand_pot(), 0, 0, 0);
        send(3, rand_pot(), 0, 0, 0);
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NC; i++) model_rate[i] = 3'd0;
        hs_count = 0;
        hs_flush = 0;
        #1;
        check("inflight_reset_valid", out_valid, 0);
        check("inflight_reset_pot", out_potential, 0);
`ifdef DECAY_STATS_EN
        check("reset_stat_processed", stat_processed, 0);
        check("reset_stat_flushed", stat_flushed, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_output_after_reset", out_valid, 0);
        send(2, 32'h3F80_0000, 0, 0, 0);
        expect_next("table_reset", 32'h3F80_0000, 1'b0);
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
